// File: rtl/wb_led_seq_pkg.sv
// Shared types and constants for the Wishbone LED pattern sequencer.
package wb_led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_STATUS   = 6'h04;
  localparam logic [5:0] OFF_PERIOD   = 6'h08;
  localparam logic [5:0] OFF_LAST     = 6'h0C;
  localparam logic [5:0] OFF_OEB      = 6'h10;
  localparam logic [5:0] OFF_PAT_BASE = 6'h20;

  localparam logic [23:0] PERIOD_RST = 24'd1000;
  localparam logic [2:0]  LAST_RST   = 3'd7;
  localparam logic [7:0]  OEB_RST    = 8'hFF;

endpackage

// File: rtl/wb_led_sequencer_btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stability counter,
// accepted level and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Any sample that agrees with the accepted level restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/wb_led_sequencer.sv
// Wishbone-programmable LED pattern sequencer: register file, slave port,
// run/pause/step FSM with step timer, and three debounced control buttons.
module wb_led_sequencer
  import wb_led_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic [2:0]  buttons,
  output logic [7:0]  leds,
  output logic [7:0]  led_enb
);

  logic [2:0] btn_level, btn_press;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (buttons[gi]),
        .level   (btn_level[gi]),
        .press   (btn_press[gi])
      );
    end
  endgenerate

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        loop_q, loop_d;
  logic [23:0] period_q, period_d;
  logic [2:0]  last_q, last_d;
  logic [7:0]  oeb_q, oeb_d;
  logic [7:0]  pattern_q [8];
  logic [7:0]  pattern_d [8];
  seq_state_t  state_q, state_d, adv_state;
  logic [2:0]  index_q, index_d, adv_index;
  logic [23:0] timer_q, timer_d, period_m1;
  logic [7:0]  leds_q, leds_d;

  logic [5:0] off;
  logic       wb_acc, wr_en, rd_en, wr_ctrl, clr_ev, pat_sel, tc;
  logic       unused_data;

  assign off         = i_wb_addr[5:0];
  assign wb_acc      = i_wb_cyc & i_wb_stb & ~ack_q & (i_wb_addr[31:6] == BASE_ADDR[31:6]);
  assign wr_en       = wb_acc & i_wb_we;
  assign rd_en       = wb_acc & ~i_wb_we;
  assign wr_ctrl     = wr_en & (off == OFF_CTRL);
  assign clr_ev      = wr_ctrl & i_wb_data[2];
  assign pat_sel     = off[5] & (off[1:0] == 2'b00);
  assign unused_data = &{1'b0, i_wb_data[31:24]};

  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_CTRL:   rd_mux = {29'd0, 1'b0, loop_q, state_q == ST_RUN};
      OFF_STATUS: rd_mux = {24'd0, btn_level, index_q, state_q};
      OFF_PERIOD: rd_mux = {8'd0, period_q};
      OFF_LAST:   rd_mux = {29'd0, last_q};
      OFF_OEB:    rd_mux = {24'd0, oeb_q};
      default:    if (pat_sel) rd_mux = {24'd0, pattern_q[off[4:2]]};
    endcase
    ack_d   = wb_acc;
    rdata_d = rd_en ? rd_mux : 32'd0;
  end

  always_comb begin
    loop_d    = loop_q;
    period_d  = period_q;
    last_d    = last_q;
    oeb_d     = oeb_q;
    pattern_d = pattern_q;
    if (wr_en) begin
      case (off)
        OFF_CTRL:   loop_d   = i_wb_data[1];
        OFF_PERIOD: period_d = i_wb_data[23:0];
        OFF_LAST:   last_d   = i_wb_data[2:0];
        OFF_OEB:    oeb_d    = i_wb_data[7:0];
        default:    if (pat_sel) pattern_d[off[4:2]] = i_wb_data[7:0];
      endcase
    end
  end

  always_comb begin
    adv_index = index_q;
    adv_state = state_q;
    if (index_q < last_q) begin
      adv_index = index_q + 3'd1;
    end else if (loop_q) begin
      adv_index = 3'd0;
    end else begin
      adv_state = ST_DONE;
    end
    period_m1 = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;
    tc        = timer_q >= period_m1;
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    timer_d = timer_q;
    if (clr_ev || btn_press[2]) begin
      state_d = ST_IDLE;
      index_d = 3'd0;
      timer_d = 24'd0;
    end else if (wr_ctrl && i_wb_data[0] && state_q != ST_RUN) begin
      state_d = ST_RUN;
      if (state_q != ST_PAUSE) begin
        index_d = 3'd0;
        timer_d = 24'd0;
      end
    end else if (wr_ctrl && !i_wb_data[0] && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (!wr_ctrl && btn_press[0]) begin
      case (state_q)
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default: begin
          state_d = ST_RUN;
          index_d = 3'd0;
          timer_d = 24'd0;
        end
      endcase
    end else if (!wr_ctrl && btn_press[1] && state_q == ST_PAUSE) begin
      state_d = adv_state;
      index_d = adv_index;
    end else if (state_q == ST_RUN) begin
      // A CTRL write that leaves RUN unchanged does not stall the step timer.
      if (tc) begin
        timer_d = 24'd0;
        state_d = adv_state;
        index_d = adv_index;
      end else begin
        timer_d = timer_q + 24'd1;
      end
    end
    leds_d = (state_d == ST_IDLE) ? 8'h00 : pattern_q[index_d];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
      loop_q    <= 1'b0;
      period_q  <= PERIOD_RST;
      last_q    <= LAST_RST;
      oeb_q     <= OEB_RST;
      pattern_q <= '{default: 8'h00};
      state_q   <= ST_IDLE;
      index_q   <= 3'd0;
      timer_q   <= 24'd0;
      leds_q    <= 8'h00;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      loop_q    <= loop_d;
      period_q  <= period_d;
      last_q    <= last_d;
      oeb_q     <= oeb_d;
      pattern_q <= pattern_d;
      state_q   <= state_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      leds_q    <= leds_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign leds      = leds_q;
  assign led_enb   = oeb_q;

endmodule
